// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller driving a 2-to-4 digit decoder.
// Double-buffered BCD word, per-slot anti-ghosting blank time, optional leading-zero blanking.
module digit_scan_ctrl #(
  parameter int unsigned PRESCALE     = 16,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic        lzb,
  output logic        a,
  output logic        b,
  output logic        digit_on,
  output logic [6:0]  seg,
  output logic        load_ack,
  output logic        frame_start
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [15:0]      shown_q, shown_d;
  logic [15:0]      pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  logic             frame_wrap;

  logic [3:0]       digit_val;
  logic             lz_blank;
  logic             digit_on_d;
  logic [6:0]       seg_d;
  logic             load_ack_d;
  logic             frame_start_d;

  function automatic logic [6:0] seg_encode(input logic [3:0] val);
    logic [6:0] enc;
    enc = 7'h00;
    case (val)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h00;
    endcase
    return enc;
  endfunction

  // State register; outputs are registered from the next-state view so a/b/digit_on/seg agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q           <= '0;
      sel_q           <= 2'd0;
      shown_q         <= 16'h0000;
      pending_q       <= 16'h0000;
      pending_valid_q <= 1'b0;
      a               <= 1'b0;
      b               <= 1'b0;
      digit_on        <= 1'b0;
      seg             <= 7'h00;
      load_ack        <= 1'b0;
      frame_start     <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      sel_q           <= sel_d;
      shown_q         <= shown_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      a               <= sel_d[1];
      b               <= sel_d[0];
      digit_on        <= digit_on_d;
      seg             <= seg_d;
      load_ack        <= load_ack_d;
      frame_start     <= frame_start_d;
    end
  end

  // Next-state: prescaler, slot select, and the frame-boundary commit of pending data.
  always_comb begin
    cnt_d           = cnt_q + CNT_W'(1);
    sel_d           = sel_q;
    shown_d         = shown_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    frame_wrap      = 1'b0;

    if (cnt_q == CNT_LAST) begin
      cnt_d      = '0;
      sel_d      = sel_q + 2'd1;
      frame_wrap = (sel_q == 2'd3);
    end

    if (frame_wrap) begin
      // A load landing on the wrap cycle bypasses pending so nothing stale is shown.
      if (load) begin
        shown_d = data_in;
      end else if (pending_valid_q) begin
        shown_d = pending_q;
      end
      pending_valid_d = 1'b0;
    end else if (load) begin
      pending_d       = data_in;
      pending_valid_d = 1'b1;
    end
  end

  // Output view of the upcoming slot, evaluated on next-state values.
  always_comb begin
    digit_val     = 4'd0;
    lz_blank      = 1'b0;
    digit_on_d    = 1'b0;
    seg_d         = 7'h00;
    load_ack_d    = 1'b0;
    frame_start_d = 1'b0;

    case (sel_d)
      2'd0: digit_val = shown_d[3:0];
      2'd1: digit_val = shown_d[7:4];
      2'd2: digit_val = shown_d[11:8];
      2'd3: digit_val = shown_d[15:12];
      default: digit_val = 4'd0;
    endcase

    case (sel_d)
      2'd3: lz_blank = (shown_d[15:12] == 4'd0);
      2'd2: lz_blank = (shown_d[15:8] == 8'h00);
      2'd1: lz_blank = (shown_d[15:4] == 12'h000);
      default: lz_blank = 1'b0;
    endcase

    digit_on_d    = (cnt_d >= CNT_BLANK) && !(lzb && lz_blank);
    seg_d         = digit_on_d ? seg_encode(digit_val) : 7'h00;
    load_ack_d    = frame_wrap && (load || pending_valid_q);
    frame_start_d = frame_wrap;
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: stimulus pushes per-cycle expectations from a
// frame-level reference model; an independent monitor pops and compares every cycle.
module tb_digit_scan_ctrl;

  localparam int P  = 4;
  localparam int BL = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = 16'h0000;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic        a, b, digit_on, load_ack, frame_start;
  logic [6:0]  seg;

  digit_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .lzb(lzb),
    .a(a), .b(b), .digit_on(digit_on), .seg(seg),
    .load_ack(load_ack), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       b;
    logic       on;
    logic [6:0] seg;
    logic       ack;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: time since reset, displayed word, last uncommitted load.
  int          phase = 0;
  logic [15:0] m_shown = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  bit          m_pv = 1'b0;
  bit          lz_cur = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  task automatic step(input bit r, input bit ld, input logic [15:0] d);
    exp_t e;
    int   c, slot, dig;
    bit   blank;
    @(negedge clk);
    rst = r; load = ld; data_in = d; lzb = lz_cur;
    e.a = 1'b0; e.b = 1'b0; e.on = 1'b0; e.seg = 7'h00; e.ack = 1'b0; e.fs = 1'b0;
    if (r) begin
      phase = 0; m_shown = 16'h0000; m_pv = 1'b0;
    end else begin
      phase++;
      if (phase % (4 * P) == 0) begin
        e.fs = 1'b1;
        if (ld) begin m_shown = d; e.ack = 1'b1; end
        else if (m_pv) begin m_shown = m_pend; e.ack = 1'b1; end
        m_pv = 1'b0;
      end else if (ld) begin
        m_pend = d; m_pv = 1'b1;
      end
      c    = phase % P;
      slot = (phase / P) % 4;
      dig  = int'((m_shown >> (4 * slot)) & 16'hF);
      blank = 1'b0;
      if (lz_cur && slot > 0) begin
        blank = 1'b1;
        for (int k = slot; k < 4; k++)
          if (((m_shown >> (4 * k)) & 16'hF) != 16'h0) blank = 1'b0;
      end
      e.a   = (slot >= 2);
      e.b   = (slot % 2 == 1);
      e.on  = (c >= BL) && !blank;
      e.seg = (e.on && dig < 10) ? seg_tab[dig] : 7'h00;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'h0000;
    for (int k = 0; k < 4; k++)
      if ($urandom_range(0, 3) != 0) w[4*k +: 4] = 4'($urandom_range(0, 15));
    return w;
  endfunction

  // Monitor: DUT presents a new slot view every cycle.
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("a", int'(a), int'(e.a));
      chk("b", int'(b), int'(e.b));
      chk("digit_on", int'(digit_on), int'(e.on));
      chk("seg", int'(seg), int'(e.seg));
      chk("load_ack", int'(load_ack), int'(e.ack));
      chk("frame_start", int'(frame_start), int'(e.fs));
    end
  end

  initial begin
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    idle(40);
    // Load in the middle of slot 1.
    while (phase % (4 * P) != 5) idle(1);
    step(1'b0, 1'b1, 16'h1234);
    idle(40);
    // Leading-zero blanking.
    lz_cur = 1'b1;
    step(1'b0, 1'b1, 16'h0050);
    idle(36);
    step(1'b0, 1'b1, 16'h0000);
    idle(36);
    lz_cur = 1'b0;
    // Overwritten pending, then non-BCD digit.
    step(1'b0, 1'b1, 16'hAAAA);
    idle(3);
    step(1'b0, 1'b1, 16'h9999);
    idle(36);
    step(1'b0, 1'b1, 16'h000F);
    idle(36);
    // Load landing exactly on the wrap cycle.
    while ((phase + 1) % (4 * P) != 0) idle(1);
    step(1'b0, 1'b1, 16'h4321);
    idle(20);
    // Reset with pending data outstanding.
    step(1'b0, 1'b1, 16'h7777);
    idle(2);
    step(1'b1, 1'b0, 16'h0000);
    idle(40);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) lz_cur = ~lz_cur;
      if ($urandom_range(0, 499) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), rand_word());
      else
        step(1'b0, ($urandom_range(0, 19) == 0), rand_word());
    end
    idle(2);
    repeat (3) @(posedge clk);
    #3;
    chk("queue_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
